// File: rtl/fc_layer.sv
// fc_layer: dense layer behind the conv/pool accelerator.
// Takes a serial stream of signed fixed-point samples and runs OUT_NUM MACs
// in parallel against weights from an external one-cycle-latency ROM. When
// a frame is complete it adds the biases, rescales, saturates (optionally
// applies ReLU) and emits the OUT_NUM results serially.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   din_st, din  sample strobe and sample (accepted only while ready)
//   w_raddr      weight ROM address (= index of next expected sample)
//   w_rdata      weights of all neurons, neuron j at [j*dwidth +: dwidth]
//   bias         per-neuron bias, neuron j at [j*dwidth +: dwidth]
//   ready        high while accumulating
//   dout/dout_st result and its one-cycle strobe; dout_last marks the final neuron
//   overrun      one-cycle pulse when a strobe arrives while not ready
module fc_layer #(
   parameter int unsigned dwidth  = 16,
   parameter int unsigned qwidth  = 11,
   parameter int unsigned IN_NUM  = 36,
   parameter int unsigned OUT_NUM = 10,
   parameter bit          RELU    = 1'b0
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              din_st,
   input  logic [dwidth-1:0]                 din,
   output logic [$clog2(IN_NUM)-1:0]         w_raddr,
   input  logic [OUT_NUM*dwidth-1:0]         w_rdata,
   input  logic [OUT_NUM*dwidth-1:0]         bias,
   output logic                              ready,
   output logic [dwidth-1:0]                 dout,
   output logic                              dout_st,
   output logic                              dout_last,
   output logic                              overrun
);

   localparam int unsigned AW   = $clog2(IN_NUM);
   localparam int unsigned JW   = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
   localparam int unsigned PW   = 2 * dwidth;
   localparam int unsigned ACCW = PW + AW;
   localparam int unsigned SUMW = ACCW + 1;
   localparam int unsigned BSW  = dwidth + qwidth;

   localparam logic signed [SUMW-1:0] SAT_MAX = SUMW'(2 ** (dwidth - 1) - 1);
   localparam logic signed [SUMW-1:0] SAT_MIN = SUMW'(-(2 ** (dwidth - 1)));

   typedef enum logic [1:0] {
      ST_ACC   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_OUT   = 2'd2
   } state_e;

   state_e                    state_q, state_d;
   logic [AW-1:0]             cnt_q, cnt_d;
   logic [JW-1:0]             j_q, j_d;
   logic [dwidth-1:0]         din_r_q, din_r_d;
   logic                      v_r_q, v_r_d;
   logic                      ready_q, ready_d;
   logic [dwidth-1:0]         dout_q, dout_d;
   logic                      dout_st_q, dout_st_d;
   logic                      dout_last_q, dout_last_d;
   logic                      overrun_q, overrun_d;
   logic signed [ACCW-1:0]    acc_q [OUT_NUM];
   logic signed [ACCW-1:0]    acc_d [OUT_NUM];

   logic signed [PW-1:0]      prod_c [OUT_NUM];
   logic signed [BSW-1:0]     bias_sh_c;
   logic signed [SUMW-1:0]    sum_c;
   logic signed [SUMW-1:0]    shr_c;
   logic [dwidth-1:0]         res_c;

   assign w_raddr   = cnt_q;
   assign ready     = ready_q;
   assign dout      = dout_q;
   assign dout_st   = dout_st_q;
   assign dout_last = dout_last_q;
   assign overrun   = overrun_q;

   // Full-precision products of the registered sample with each neuron's weight.
   always_comb begin
      for (int j = 0; j < OUT_NUM; j++) begin
         prod_c[j] = PW'($signed(din_r_q)) * PW'($signed(w_rdata[j*dwidth +: dwidth]));
      end
   end

   // Result for neuron j_q: add bias in accumulator scale, rescale (floor), saturate.
   always_comb begin
      bias_sh_c = {bias[j_q*dwidth +: dwidth], {qwidth{1'b0}}};
      sum_c     = SUMW'(acc_q[j_q]) + SUMW'(bias_sh_c);
      shr_c     = sum_c >>> qwidth;
      if (shr_c > SAT_MAX) begin
         res_c = {1'b0, {(dwidth-1){1'b1}}};
      end else if (shr_c < SAT_MIN) begin
         res_c = {1'b1, {(dwidth-1){1'b0}}};
      end else begin
         res_c = shr_c[dwidth-1:0];
      end
      if (RELU && res_c[dwidth-1]) begin
         res_c = '0;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      j_d         = j_q;
      din_r_d     = din_r_q;
      v_r_d       = 1'b0;
      dout_d      = dout_q;
      dout_st_d   = 1'b0;
      dout_last_d = 1'b0;
      overrun_d   = din_st && !ready_q;
      acc_d       = acc_q;

      // MAC runs one cycle behind acceptance so the ROM data lines up with din_r.
      if (v_r_q) begin
         for (int j = 0; j < OUT_NUM; j++) begin
            acc_d[j] = acc_q[j] + {{AW{prod_c[j][PW-1]}}, prod_c[j]};
         end
      end

      unique case (state_q)
         ST_ACC: begin
            if (din_st) begin
               din_r_d = din;
               v_r_d   = 1'b1;
               cnt_d   = cnt_q + AW'(1);
               if (cnt_q == AW'(IN_NUM - 1)) begin
                  state_d = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            state_d = ST_OUT;
            j_d     = '0;
         end
         ST_OUT: begin
            dout_d    = res_c;
            dout_st_d = 1'b1;
            j_d       = j_q + JW'(1);
            if (j_q == JW'(OUT_NUM - 1)) begin
               dout_last_d = 1'b1;
               cnt_d       = '0;
               j_d         = '0;
               state_d     = ST_ACC;
               for (int j = 0; j < OUT_NUM; j++) begin
                  acc_d[j] = '0;
               end
            end
         end
         default: begin
            state_d = ST_ACC;
         end
      endcase

      ready_d = (state_d == ST_ACC);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ACC;
         cnt_q       <= '0;
         j_q         <= '0;
         din_r_q     <= '0;
         v_r_q       <= 1'b0;
         ready_q     <= 1'b1;
         dout_q      <= '0;
         dout_st_q   <= 1'b0;
         dout_last_q <= 1'b0;
         overrun_q   <= 1'b0;
         for (int j = 0; j < OUT_NUM; j++) begin
            acc_q[j] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         j_q         <= j_d;
         din_r_q     <= din_r_d;
         v_r_q       <= v_r_d;
         ready_q     <= ready_d;
         dout_q      <= dout_d;
         dout_st_q   <= dout_st_d;
         dout_last_q <= dout_last_d;
         overrun_q   <= overrun_d;
         acc_q       <= acc_d;
      end
   end

endmodule

// File: tb/tb_fc_layer.sv
// Testbench for fc_layer: directed frames with hand-computed results, plus
// random frames against a behavioural model, overrun and mid-frame reset.
module tb_fc_layer;

   localparam int unsigned DW      = 16;
   localparam int unsigned QW      = 11;
   localparam int unsigned IN_NUM  = 36;
   localparam int unsigned OUT_NUM = 10;
   localparam int unsigned AW      = $clog2(IN_NUM);

   logic                   clk    = 1'b0;
   logic                   rst_n  = 1'b0;
   logic                   din_st = 1'b0;
   logic [DW-1:0]          din    = '0;
   logic [OUT_NUM*DW-1:0]  bias_bus;
   logic [AW-1:0]          w_raddr, w_raddr_r;
   logic [OUT_NUM*DW-1:0]  w_rdata, w_rdata_r;
   logic                   ready, ready_r;
   logic [DW-1:0]          dout, dout_r;
   logic                   dout_st, dout_st_r, dout_last, dout_last_r;
   logic                   overrun, overrun_r;

   int samp [IN_NUM];
   int wt   [IN_NUM][OUT_NUM];
   int bs   [OUT_NUM];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int ovr_cnt = 0;

   typedef struct {
      int val;
      bit last;
      bit rdy;
      int c;
   } ev_t;
   ev_t q0[$];
   ev_t q1[$];

   typedef struct {
      int din;
      int w;
      int b;
      bit first_only;
      int exp;
      int exp_r;
   } vec_t;
   vec_t vecs [6];

   fc_layer #(.dwidth(DW), .qwidth(QW), .IN_NUM(IN_NUM), .OUT_NUM(OUT_NUM), .RELU(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .din_st(din_st), .din(din), .w_raddr(w_raddr),
      .w_rdata(w_rdata), .bias(bias_bus), .ready(ready), .dout(dout),
      .dout_st(dout_st), .dout_last(dout_last), .overrun(overrun)
   );

   fc_layer #(.dwidth(DW), .qwidth(QW), .IN_NUM(IN_NUM), .OUT_NUM(OUT_NUM), .RELU(1'b1)) dut_relu (
      .clk(clk), .rst_n(rst_n), .din_st(din_st), .din(din), .w_raddr(w_raddr_r),
      .w_rdata(w_rdata_r), .bias(bias_bus), .ready(ready_r), .dout(dout_r),
      .dout_st(dout_st_r), .dout_last(dout_last_r), .overrun(overrun_r)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Weight ROMs with one-cycle read latency.
   always @(posedge clk) begin
      for (int j = 0; j < OUT_NUM; j++) begin
         w_rdata[j*DW +: DW]   <= (int'(w_raddr) < IN_NUM)   ? DW'(wt[w_raddr][j])   : '0;
         w_rdata_r[j*DW +: DW] <= (int'(w_raddr_r) < IN_NUM) ? DW'(wt[w_raddr_r][j]) : '0;
      end
   end

   always_comb begin
      for (int j = 0; j < OUT_NUM; j++) bias_bus[j*DW +: DW] = DW'(bs[j]);
   end

   // Output monitor.
   always @(negedge clk) begin
      ev_t e;
      if (dout_st) begin
         e.val = int'($signed(dout)); e.last = dout_last; e.rdy = ready; e.c = cyc;
         q0.push_back(e);
      end
      if (dout_st_r) begin
         e.val = int'($signed(dout_r)); e.last = dout_last_r; e.rdy = ready_r; e.c = cyc;
         q1.push_back(e);
      end
      if (overrun) ovr_cnt++;
   end

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic int model(input int j, input bit relu);
      longint acc = 0;
      longint r;
      for (int i = 0; i < IN_NUM; i++) acc += longint'(samp[i]) * longint'(wt[i][j]);
      acc += longint'(bs[j]) <<< QW;
      r = acc >>> QW;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      if (relu && r < 0) r = 0;
      return int'(r);
   endfunction

   task automatic drive_frame(input int max_gap, output int e_cyc);
      for (int i = 0; i < IN_NUM; i++) begin
         int g;
         g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         repeat (g) begin
            @(negedge clk);
            din_st = 1'b0;
         end
         @(negedge clk);
         din_st = 1'b1;
         din    = DW'(samp[i]);
      end
      e_cyc = cyc + 1;
      @(negedge clk);
      din_st = 1'b0;
   endtask

   task automatic check_frame(input string tag, input int e_cyc, input int exp[OUT_NUM],
                              input int exp_r[OUT_NUM], output int got[OUT_NUM]);
      int n = 0;
      ev_t e;
      while ((q0.size() < OUT_NUM || q1.size() < OUT_NUM) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("%s count", tag), q0.size(), OUT_NUM);
      check($sformatf("%s relu count", tag), q1.size(), OUT_NUM);
      for (int k = 0; k < OUT_NUM; k++) begin
         got[k] = 0;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            got[k] = e.val;
            check($sformatf("%s dout[%0d]", tag, k), e.val, exp[k]);
            check($sformatf("%s cycle[%0d]", tag, k), e.c, e_cyc + 2 + k);
            check($sformatf("%s last[%0d]", tag, k), int'(e.last), (k == OUT_NUM - 1) ? 1 : 0);
            if (k >= OUT_NUM - 2)
               check($sformatf("%s ready[%0d]", tag, k), int'(e.rdy), (k == OUT_NUM - 1) ? 1 : 0);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check($sformatf("%s relu dout[%0d]", tag, k), e.val, exp_r[k]);
         end
      end
   endtask

   task automatic run_model_frame(input string tag, input int max_gap, output int got[OUT_NUM]);
      int e_cyc;
      int exp [OUT_NUM];
      int exp_r [OUT_NUM];
      for (int j = 0; j < OUT_NUM; j++) begin
         exp[j]   = model(j, 1'b0);
         exp_r[j] = model(j, 1'b1);
      end
      q0.delete(); q1.delete();
      drive_frame(max_gap, e_cyc);
      check($sformatf("%s ready low", tag), int'(ready), 0);
      check_frame(tag, e_cyc, exp, exp_r, got);
   endtask

   task automatic randomize_frame();
      for (int i = 0; i < IN_NUM; i++) begin
         samp[i] = int'($urandom_range(4095, 0)) - 2048;
         for (int j = 0; j < OUT_NUM; j++) wt[i][j] = int'($urandom_range(1023, 0)) - 512;
      end
      for (int j = 0; j < OUT_NUM; j++) bs[j] = int'($urandom_range(8191, 0)) - 4096;
   endtask

   initial begin
      int e_cyc;
      int exp [OUT_NUM];
      int exp_r [OUT_NUM];
      int got [OUT_NUM];
      int got2 [OUT_NUM];

      vecs[0] = '{din: 2048, w: 128,   b: 0,    first_only: 1'b0, exp: 4608,   exp_r: 4608};
      vecs[1] = '{din: 2048, w: 128,   b: 1024, first_only: 1'b0, exp: 5632,   exp_r: 5632};
      vecs[2] = '{din: 2048, w: -2048, b: 0,    first_only: 1'b0, exp: -32768, exp_r: 0};
      vecs[3] = '{din: 2048, w: 2048,  b: 0,    first_only: 1'b0, exp: 32767,  exp_r: 32767};
      vecs[4] = '{din: 1,    w: -1,    b: 0,    first_only: 1'b1, exp: -1,     exp_r: 0};
      vecs[5] = '{din: 1,    w: 1,     b: 0,    first_only: 1'b1, exp: 0,      exp_r: 0};

      for (int i = 0; i < IN_NUM; i++) begin
         samp[i] = 0;
         for (int j = 0; j < OUT_NUM; j++) wt[i][j] = 0;
      end
      for (int j = 0; j < OUT_NUM; j++) bs[j] = 0;

      // Reset values.
      #12;
      check("reset dout", int'(dout), 0);
      check("reset dout_st", int'(dout_st), 0);
      check("reset dout_last", int'(dout_last), 0);
      check("reset overrun", int'(overrun), 0);
      check("reset w_raddr", int'(w_raddr), 0);
      check("reset ready", int'(ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed frames.
      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < IN_NUM; i++) begin
            samp[i] = (vecs[v].first_only && i != 0) ? 0 : vecs[v].din;
            for (int j = 0; j < OUT_NUM; j++) wt[i][j] = vecs[v].w;
         end
         for (int j = 0; j < OUT_NUM; j++) begin
            bs[j]    = vecs[v].b;
            exp[j]   = vecs[v].exp;
            exp_r[j] = vecs[v].exp_r;
         end
         q0.delete(); q1.delete();
         drive_frame(0, e_cyc);
         check($sformatf("vec%0d ready low", v), int'(ready), 0);
         check_frame($sformatf("vec%0d", v), e_cyc, exp, exp_r, got);
      end

      // Random data, back-to-back versus gapped delivery.
      randomize_frame();
      run_model_frame("rnd b2b", 0, got);
      run_model_frame("rnd gap", 3, got2);
      for (int j = 0; j < OUT_NUM; j++) check($sformatf("b2b vs gap[%0d]", j), got2[j], got[j]);

      // Strobe during OUT is dropped and flagged.
      randomize_frame();
      for (int j = 0; j < OUT_NUM; j++) begin
         exp[j]   = model(j, 1'b0);
         exp_r[j] = model(j, 1'b1);
      end
      q0.delete(); q1.delete();
      ovr_cnt = 0;
      drive_frame(0, e_cyc);
      while (cyc < e_cyc + 4) @(negedge clk);
      din_st = 1'b1;
      din    = DW'(12345);
      @(negedge clk);
      din_st = 1'b0;
      check("overrun pulse", int'(overrun), 1);
      @(negedge clk);
      check("overrun clears", int'(overrun), 0);
      check_frame("ovr frame", e_cyc, exp, exp_r, got);
      check("overrun count", ovr_cnt, 1);
      randomize_frame();
      run_model_frame("after ovr", 2, got);

      // Reset after 20 samples discards the partial frame.
      randomize_frame();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         din_st = 1'b1;
         din    = DW'(samp[i]);
      end
      @(negedge clk);
      din_st = 1'b0;
      check("mid w_raddr", int'(w_raddr), 20);
      #2 rst_n = 1'b0;
      #1;
      check("mid rst dout", int'(dout), 0);
      check("mid rst ready", int'(ready), 1);
      check("mid rst w_raddr", int'(w_raddr), 0);
      check("mid rst dout_st", int'(dout_st), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      randomize_frame();
      run_model_frame("after rst", 0, got);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/fc_layer.md
# fc_layer

Fully-connected (dense) stage placed directly downstream of the convolution/pooling accelerator. It consumes the serial pooled feature stream (one signed fixed-point sample per strobe) and multiplies each sample against one weight per output neuron, with OUT_NUM MACs running in parallel. When a frame is complete it adds the biases, rescales and saturates the results, and emits OUT_NUM results serially. Weights and biases come from an external synchronous ROM with one-cycle read latency, addressed by this block.

## Interface
- dwidth, 16, sample/weight/bias/result width, signed two's complement
- qwidth, 11, fractional bits (1.0 = 2^qwidth)
- IN_NUM, 36, samples per frame (6x6 pooled map)
- OUT_NUM, 10, output neurons
- RELU, 0, 1 = clamp negative results to 0 after saturation

- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- din_st  input  1  din valid, one sample per high cycle, gaps allowed
- din  input  dwidth  feature sample
- w_raddr  output  clog2(IN_NUM)  weight ROM address = index of next expected sample
- w_rdata  input  OUT_NUM*dwidth  weights for all neurons; neuron j at [j*dwidth +: dwidth]; valid 1 cycle after w_raddr
- bias  input  OUT_NUM*dwidth  per-neuron bias, static during a frame
- ready  output  1  high in ACC state; samples accepted only while high
- dout  output  dwidth  result
- dout_st  output  1  one-cycle pulse per valid dout
- dout_last  output  1  coincident with dout_st for neuron OUT_NUM-1
- overrun  output  1  one-cycle pulse when din_st is sampled while ready=0

## Operation
- States: ACC, FLUSH, OUT. Reset state is ACC with cnt=0, j=0, all accumulators 0.
- ACC:
  - On each edge with din_st=1: din_r<=din, v_r<=1, cnt<=cnt+1.
  - w_raddr = cnt (registered).
  - When cnt reaches IN_NUM-1 and din_st=1, go to FLUSH.
- MAC stage: on each edge with v_r=1, acc[j] += din_r * w_rdata[j] for every j.
  - Product width is 2*dwidth, full precision.
  - Accumulator width is 2*dwidth+clog2(IN_NUM). No intermediate rounding.
- FLUSH: one cycle, for the final MAC; then go to OUT with j=0.
- OUT: each edge loads dout with the result for neuron j, pulses dout_st, and increments j.
  - At j=OUT_NUM-1, also assert dout_last, clear acc[], cnt and j, and go to ACC.
- Result computation:
  - r = (acc[j] + (sign-extended bias[j] <<< qwidth)) >>> qwidth (arithmetic shift, truncation toward -inf).
  - Saturate r to [-2^(dwidth-1), 2^(dwidth-1)-1].
  - If RELU=1, negative r becomes 0.
- din_st while ready=0: the sample is dropped, overrun pulses, and state and accumulators are unaffected.
- Reset mid-frame: the partial frame is discarded and all state returns to reset values.

## Timing
- Reset values: dout=0, dout_st=0, dout_last=0, overrun=0, w_raddr=0, ready=1.
- Let edge E sample the final din_st=1 of a frame:
  - E+1: final MAC.
  - E+2..E+1+OUT_NUM: dout/dout_st for neurons 0..OUT_NUM-1 on consecutive cycles, with no gaps.
- ready is low from after E until after E+1+OUT_NUM. The next frame's first sample is accepted at E+2+OUT_NUM at the earliest.
- Back-to-back din_st is supported at full rate. The 1-cycle ROM latency is hidden by the din_r/v_r register.
- Per-frame occupancy: IN_NUM accepted samples + 1 + OUT_NUM cycles.
- bias is sampled during OUT only.

## Test plan
- Frame of 36 samples din=2048, all weights 128, bias 0 -> all 10 outputs 4608 at E+2..E+11, dout_last on the 10th.
- Same frame with bias[j]=1024 -> 5632; with weights -2048 -> -32768 (saturation); with weights +2048 -> 32767; RELU=1 with weights -2048 -> 0.
- Truncation check: sample0 din=1 with w=-1, all other samples 0, bias 0 -> dout=-1. sample0 din=1 with w=+1 -> 0.
- Back-to-back frame vs frame with random 0-3 cycle gaps, random data -> identical outputs, matching the reference model bit-exactly.
- din_st pulsed during OUT -> sample ignored, overrun=1 for one cycle, current outputs unchanged, next frame correct.
- rst_n asserted after 20 samples -> outputs 0, ready=1, w_raddr=0. A following full frame produces the correct results.
